// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, pixel/address types and draw command encodings
package fb_pkg;

   localparam int FB_W    = 214;
   localparam int FB_H    = 160;
   localparam int FB_SIZE = FB_W * FB_H;
   localparam int ADDR_W  = 16;
   localparam int COORD_W = 8;

   typedef logic [2:0]         fb_pixel_t;
   typedef logic [ADDR_W-1:0]  fb_addr_t;
   typedef logic [COORD_W-1:0] fb_coord_t;

   typedef enum logic [1:0] {
      OP_PIXEL = 2'b00,
      OP_RECT  = 2'b01,
      OP_CLEAR = 2'b10,
      OP_RSVD  = 2'b11
   } draw_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } draw_state_e;

   localparam fb_coord_t X_MAX  = COORD_W'(FB_W - 1);
   localparam fb_coord_t Y_MAX  = COORD_W'(FB_H - 1);
   localparam fb_addr_t  FB_W_A = ADDR_W'(FB_W);

   // Constant multiply; synthesis reduces it to a shift-add tree.
   function automatic fb_addr_t row_addr(input fb_coord_t y);
      return fb_addr_t'(y) * FB_W_A;
   endfunction

endpackage

// File: rtl/fb_draw.sv
// rtl/fb_draw.sv - command-driven pixel/rect/clear writer into the linear framebuffer write port
module fb_draw
   import fb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_sync,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [COORD_W-1:0] cmd_x0,
   input  logic [COORD_W-1:0] cmd_y0,
   input  logic [COORD_W-1:0] cmd_x1,
   input  logic [COORD_W-1:0] cmd_y1,
   input  logic [2:0]         cmd_colour,
   output logic [ADDR_W-1:0]  fb_waddr,
   output logic [2:0]         fb_wdata,
   output logic               fb_we,
   output logic               busy,
   output logic               done
);

   draw_state_e state;
   fb_coord_t   x, y, x0_r, x1c_r, y1c_r;
   fb_addr_t    row_base;

   fb_coord_t   n_x0, n_y0, n_x1, n_y1, n_x1c, n_y1c;
   logic        n_empty;

   always_comb begin
      n_x0 = cmd_x0;
      n_y0 = cmd_y0;
      n_x1 = cmd_x1;
      n_y1 = cmd_y1;
      case (draw_op_e'(cmd_op))
         OP_PIXEL: begin
            n_x1 = cmd_x0;
            n_y1 = cmd_y0;
         end
         OP_CLEAR: begin
            n_x0 = '0;
            n_y0 = '0;
            n_x1 = X_MAX;
            n_y1 = Y_MAX;
         end
         default: ;
      endcase
      n_x1c   = (n_x1 > X_MAX) ? X_MAX : n_x1;
      n_y1c   = (n_y1 > Y_MAX) ? Y_MAX : n_y1;
      n_empty = (n_x0 > n_x1c) || (n_y0 > n_y1c) || (cmd_op == OP_RSVD);
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;

   // The write port registers are loaded with the first pixel at accept, so
   // each RUN cycle presents the pixel at (x, y) and prepares the next one.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state    <= IDLE;
         x        <= '0;
         y        <= '0;
         x0_r     <= '0;
         x1c_r    <= '0;
         y1c_r    <= '0;
         row_base <= '0;
         fb_we    <= 1'b0;
         fb_waddr <= '0;
         fb_wdata <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  if (n_empty) begin
                     // Empty commands complete immediately and leave the block ready.
                     done <= 1'b1;
                  end else begin
                     state    <= RUN;
                     x        <= n_x0;
                     y        <= n_y0;
                     x0_r     <= n_x0;
                     x1c_r    <= n_x1c;
                     y1c_r    <= n_y1c;
                     row_base <= row_addr(n_y0);
                     fb_we    <= 1'b1;
                     fb_waddr <= row_addr(n_y0) + fb_addr_t'(n_x0);
                     fb_wdata <= cmd_colour;
                  end
               end
            end
            RUN: begin
               if (x < x1c_r) begin
                  x        <= x + 1'b1;
                  fb_waddr <= fb_waddr + 1'b1;
               end else if (y < y1c_r) begin
                  x        <= x0_r;
                  y        <= y + 1'b1;
                  row_base <= row_base + FB_W_A;
                  fb_waddr <= row_base + FB_W_A + fb_addr_t'(x0_r);
               end else begin
                  fb_we <= 1'b0;
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_draw.sv
// tb/tb_fb_draw.sv - table, random and corner-sequence checks of fb_draw against a pixel-list model
module tb_fb_draw;
   import fb_pkg::*;

   logic        clk = 1'b0;
   logic        rst_sync = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [7:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
   logic [2:0]  cmd_colour = '0;
   logic        cmd_ready, fb_we, busy, done;
   logic [15:0] fb_waddr;
   logic [2:0]  fb_wdata;

   fb_draw dut (
      .clk(clk), .rst_sync(rst_sync), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
      .cmd_colour(cmd_colour), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata), .fb_we(fb_we),
      .busy(busy), .done(done)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad = 0;
   int exp_q[$];
   int obs_n, obs_first, obs_last;

   typedef struct {
      logic [1:0] op;
      int         x0, y0, x1, y1;
      logic [2:0] col;
      int         n, first, last;
   } vec_t;
   vec_t tv[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
      end
   endtask

   // Expected pixel list: every clipped (x,y) in row-major order, addr = y*FB_W + x.
   function automatic void model(input logic [1:0] op, input int x0, input int y0,
                                 input int x1, input int y1);
      int ax0 = x0, ay0 = y0, ax1 = x1, ay1 = y1;
      exp_q.delete();
      if (op == 2'b11) return;
      if (op == 2'b00) begin ax1 = x0; ay1 = y0; end
      if (op == 2'b10) begin ax0 = 0; ay0 = 0; ax1 = FB_W - 1; ay1 = FB_H - 1; end
      if (ax1 > FB_W - 1) ax1 = FB_W - 1;
      if (ay1 > FB_H - 1) ay1 = FB_H - 1;
      for (int yy = ay0; yy <= ay1; yy++)
         for (int xx = ax0; xx <= ax1; xx++)
            exp_q.push_back(yy * FB_W + xx);
   endfunction

   // Called at a negedge; returns at the negedge of cycle T+1.
   task automatic issue(input logic [1:0] op, input int x0, input int y0, input int x1,
                        input int y1, input logic [2:0] col, input bit release_v);
      int w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", cmd_ready, 1);
      cmd_op = op;
      cmd_x0 = 8'(x0); cmd_y0 = 8'(y0); cmd_x1 = 8'(x1); cmd_y1 = 8'(y1);
      cmd_colour = col;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (release_v) cmd_valid = 1'b0;
   endtask

   task automatic expect_burst(input logic [2:0] col);
      int n = exp_q.size();
      int lim = (n == 0) ? 1 : n + 2;
      bit rdy;
      obs_n = 0; obs_first = -1; obs_last = -1;
      for (int k = 1; k <= lim; k++) begin
         if (k > 1) @(negedge clk);
         rdy = (n == 0) ? 1'b1 : (k == n + 2);
         check("we", fb_we, (k <= n));
         check("done", done, (n == 0) ? 1 : (k == n + 1));
         check("ready", cmd_ready, rdy);
         check("busy", busy, !rdy);
         if (fb_we) begin
            obs_n++;
            if (obs_first < 0) obs_first = fb_waddr;
            obs_last = fb_waddr;
            if (k <= n) begin
               check("addr", fb_waddr, exp_q[k-1]);
               check("data", fb_wdata, col);
            end
         end
      end
   endtask

   initial begin
      int x0, y0, x1, y1;
      logic [1:0] op;
      logic [2:0] col;

      tv[0] = '{2'b00,   5,   3,   0,   0, 3'b101,     1,   647,   647};
      tv[1] = '{2'b01,  10,  20,  12,  21, 3'b010,     6,  4290,  4506};
      tv[2] = '{2'b01, 212, 158, 250, 200, 3'b011,     4, 34024, 34239};
      tv[3] = '{2'b01,  50,  10,  40,  20, 3'b111,     0,    -1,    -1};
      tv[4] = '{2'b11,   1,   1,   5,   5, 3'b111,     0,    -1,    -1};
      tv[5] = '{2'b00, 220,   7,   0,   0, 3'b110,     0,    -1,    -1};
      tv[6] = '{2'b00, 213, 159,   9,   9, 3'b111,     1, 34239, 34239};
      tv[7] = '{2'b10, 100,  90,   3,   4, 3'b000, 34240,     0, 34239};

      repeat (3) @(negedge clk);
      check("rst_ready", cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_we", fb_we, 0);
      check("rst_done", done, 0);
      check("rst_waddr", fb_waddr, 0);
      check("rst_wdata", fb_wdata, 0);
      rst_sync = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         model(tv[i].op, tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1);
         issue(tv[i].op, tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1, tv[i].col, 1'b1);
         expect_burst(tv[i].col);
         check("count", obs_n, tv[i].n);
         if (tv[i].n > 0) begin
            check("first_addr", obs_first, tv[i].first);
            check("last_addr", obs_last, tv[i].last);
         end
      end

      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 2'b11 : (($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01);
         col = 3'($urandom_range(0, 7));
         x0 = $urandom_range(0, 230);
         y0 = $urandom_range(0, 170);
         x1 = x0 + $urandom_range(0, 6);
         y1 = y0 + $urandom_range(0, 4);
         if ($urandom_range(0, 7) == 0 && x0 > 0) x1 = x0 - 1;
         if (x1 > 255) x1 = 255;
         if (y1 > 255) y1 = 255;
         model(op, x0, y0, x1, y1);
         issue(op, x0, y0, x1, y1, col, 1'b1);
         expect_burst(col);
      end

      // Command held valid through busy: the new fields are only taken when ready returns.
      model(2'b00, 30, 40, 0, 0);
      issue(2'b00, 30, 40, 0, 0, 3'b001, 1'b0);
      cmd_op = 2'b01; cmd_x0 = 8'd60; cmd_y0 = 8'd70; cmd_x1 = 8'd61; cmd_y1 = 8'd71;
      cmd_colour = 3'b100;
      expect_burst(3'b001);
      model(2'b01, 60, 70, 61, 71);
      issue(2'b01, 60, 70, 61, 71, 3'b100, 1'b1);
      expect_burst(3'b100);
      check("held_count", obs_n, 4);
      check("held_first", obs_first, 70 * 214 + 60);

      // Reset during a CLEAR after its 100th write.
      model(2'b10, 0, 0, 0, 0);
      issue(2'b10, 0, 0, 0, 0, 3'b110, 1'b1);
      for (int k = 1; k <= 100; k++) begin
         if (k > 1) @(negedge clk);
         check("clr_we", fb_we, 1);
         check("clr_addr", fb_waddr, k - 1);
      end
      rst_sync = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_sync = 1'b0;
      check("mid_rst_we", fb_we, 0);
      check("mid_rst_ready", cmd_ready, 1);
      check("mid_rst_done", done, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("post_rst_we", fb_we, 0);
         check("post_rst_done", done, 0);
      end
      model(2'b00, 5, 3, 0, 0);
      issue(2'b00, 5, 3, 0, 0, 3'b101, 1'b1);
      expect_burst(3'b101);
      check("post_rst_pixel", obs_first, 647);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
